// File: rtl/game_pkg.sv
// game_pkg: shared flow-state encoding and default timing constants for game_flow_ctrl.
`default_nettype none

package game_pkg;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_PLAY     = 3'd1,
        FS_DYING    = 3'd2,
        FS_RESPAWN  = 3'd3,
        FS_FLAG     = 3'd4,
        FS_GAMEOVER = 3'd5,
        FS_WIN      = 3'd6
    } flow_state_t;

    localparam int START_LIVES  = 3;
    localparam int START_TIME   = 400;
    localparam int TICK_FRAMES  = 24;
    localparam int DEATH_FRAMES = 120;
    localparam int FLAG_FRAMES  = 90;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter; done_o is high in the last enabled frame of a run.
`default_nettype none

module frame_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = en_i && !load_i && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: play/death/flag/respawn sequencing, lives and level timer.
// Build option: define GAME_TIMER_EN to enable the level countdown and timeout deaths.
`default_nettype none

module game_flow_ctrl #(
    parameter int START_LIVES  = game_pkg::START_LIVES,
    parameter int START_TIME   = game_pkg::START_TIME,
    parameter int TICK_FRAMES  = game_pkg::TICK_FRAMES,
    parameter int DEATH_FRAMES = game_pkg::DEATH_FRAMES,
    parameter int FLAG_FRAMES  = game_pkg::FLAG_FRAMES
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       game_active,
    input  logic       mario_hit,
    input  logic       mario_fell,
    input  logic       flag_reached,
    output logic       game_over_screen,
    output logic       win,
    output logic       freeze,
    output logic       respawn,
    output logic [1:0] lives,
    output logic [8:0] time_left,
    output logic [2:0] flow_state
);

    import game_pkg::*;

    localparam logic [2:0] S_IDLE     = FS_IDLE;
    localparam logic [2:0] S_PLAY     = FS_PLAY;
    localparam logic [2:0] S_DYING    = FS_DYING;
    localparam logic [2:0] S_RESPAWN  = FS_RESPAWN;
    localparam logic [2:0] S_FLAG     = FS_FLAG;
    localparam logic [2:0] S_GAMEOVER = FS_GAMEOVER;
    localparam logic [2:0] S_WIN      = FS_WIN;

    // Sized to hold every frame-count parameter so one width serves all builds.
    localparam int SEQ_MAX = max_int(max_int(DEATH_FRAMES, FLAG_FRAMES), TICK_FRAMES);
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    localparam logic [SEQ_W-1:0] DEATH_LOAD = SEQ_W'(DEATH_FRAMES - 1);
    localparam logic [SEQ_W-1:0] FLAG_LOAD  = SEQ_W'(FLAG_FRAMES - 1);
    localparam logic [8:0]       TIME_INIT  = 9'(START_TIME);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

    logic [2:0]       state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [8:0]       time_q;
    logic             seq_load;
    logic [SEQ_W-1:0] seq_val;
    logic             seq_en;
    logic             seq_done;
    logic             timeout;

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        seq_load = 1'b0;
        seq_val  = DEATH_LOAD;
        case (state_q)
            S_IDLE: begin
                if (game_active) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INIT;
                end
            end
            S_PLAY: begin
                if (flag_reached) begin
                    state_d  = S_FLAG;
                    seq_load = 1'b1;
                    seq_val  = FLAG_LOAD;
                end else if (mario_hit || mario_fell || timeout) begin
                    state_d  = S_DYING;
                    seq_load = 1'b1;
                    lives_d  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end
            end
            S_DYING: begin
                if (seq_done) begin
                    state_d = (lives_q == 2'd0) ? S_GAMEOVER : S_RESPAWN;
                end
            end
            S_RESPAWN: state_d = S_PLAY;
            S_FLAG: begin
                if (seq_done) begin
                    state_d = S_WIN;
                end
            end
            S_GAMEOVER, S_WIN: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
        // Leaving the game screen aborts everything but keeps the HUD values.
        if (!game_active && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            lives_d  = lives_q;
            seq_load = 1'b0;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            lives_q <= 2'd0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
        end
    end

    assign seq_en = game_active && ((state_q == S_DYING) || (state_q == S_FLAG));

    frame_timer #(
        .WIDTH (SEQ_W)
    ) u_frame_timer (
        .clk        (frame_clk),
        .rst_n      (Reset_n),
        .load_i     (seq_load),
        .load_val_i (seq_val),
        .en_i       (seq_en),
        .done_o     (seq_done)
    );

`ifdef GAME_TIMER_EN
    localparam int               TICK_W    = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_FRAMES - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [8:0]        time_d;

    always_comb begin
        tick_d = tick_q;
        time_d = time_q;
        if (game_active) begin
            case (state_q)
                S_IDLE, S_RESPAWN: begin
                    tick_d = '0;
                    time_d = TIME_INIT;
                end
                S_PLAY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        time_d = (time_q == 9'd0) ? 9'd0 : time_q - 9'd1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    tick_d = tick_q;
                    time_d = time_q;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_q <= '0;
            time_q <= 9'd0;
        end else begin
            tick_q <= tick_d;
            time_q <= time_d;
        end
    end

    // Registered compare: a zero reached on one edge kills Mario on the next.
    assign timeout = (time_q == 9'd0);
`else
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            time_q <= 9'd0;
        end else begin
            time_q <= TIME_INIT;
        end
    end

    assign timeout = 1'b0;
`endif

    assign flow_state       = state_q;
    assign lives            = lives_q;
    assign time_left        = time_q;
    assign freeze           = (state_q == S_DYING) || (state_q == S_FLAG);
    assign respawn          = (state_q == S_RESPAWN);
    assign game_over_screen = (state_q == S_GAMEOVER);
    assign win              = (state_q == S_WIN);

endmodule

`default_nettype wire

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter START_LIVES, 3, lives loaded when a game starts (1..3).
REQ-002 SHALL have parameter START_TIME, 400, level timer value in game-time units (max 511).
REQ-003 SHALL have parameter TICK_FRAMES, 24, frames per game-time unit.
REQ-004 SHALL have parameter DEATH_FRAMES, 120, frames of the death freeze.
REQ-005 SHALL have parameter FLAG_FRAMES, 90, frames of the flag-pole sequence before win.
REQ-006 SHALL have port frame_clk  in  1  frame-rate clock; all logic on its rising edge.
REQ-007 SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port game_active  in  1  high while the screen sequencer is in its game screen.
REQ-009 SHALL have port mario_hit  in  1  enemy contact this frame.
REQ-010 SHALL have port mario_fell  in  1  Mario below the playfield this frame.
REQ-011 SHALL have port flag_reached  in  1  Mario touched the flag pole this frame.
REQ-012 SHALL have port game_over_screen  out  1  level request to the screen sequencer for the lose screen.
REQ-013 SHALL have port win  out  1  level request to the screen sequencer for the win screen.
REQ-014 SHALL have port freeze  out  1  high in DYING and FLAG; physics/enemies halt.
REQ-015 SHALL have port respawn  out  1  one-frame pulse; Mario and scroll return to level start.
REQ-016 SHALL have port lives  out  2  remaining lives.
REQ-017 SHALL have port time_left  out  9  remaining level time.
REQ-018 SHALL have port flow_state  out  3  current state encoding, for debug and HUD.

Function
REQ-019 SHALL implement states IDLE=0, PLAY=1, DYING=2, RESPAWN=3, FLAG=4, GAMEOVER=5, WIN=6.
REQ-020 IDLE: on game_active=1 -> PLAY; same edge loads lives=START_LIVES, time_left=START_TIME, tick=0.
REQ-021 PLAY: tick counts 0..TICK_FRAMES-1 and wraps; on wrap time_left decrements, saturating at 0.
REQ-022 PLAY: death event = mario_hit | mario_fell | timeout; -> DYING, lives decrements by 1 (saturating at 0) on the same edge.
REQ-023 PLAY: flag_reached -> FLAG; flag_reached takes priority over a death event in the same frame.
REQ-024 Simultaneous mario_hit and mario_fell SHALL count as one death (one decrement).
REQ-025 DYING/FLAG: frame counter starts at 0 on entry; exits after exactly DEATH_FRAMES / FLAG_FRAMES frames in state; all event inputs ignored.
REQ-026 DYING exit: lives==0 -> GAMEOVER, else -> RESPAWN.
REQ-027 RESPAWN: one frame; respawn=1; time_left reloads START_TIME, tick=0; -> PLAY.
REQ-028 GAMEOVER: game_over_screen=1; WIN: win=1; both held until game_active=0.
REQ-029 Any state except IDLE: game_active=0 -> IDLE next edge; counters frozen, lives/time_left hold last value.
REQ-030 Outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-031 Reset_n=0 SHALL force, asynchronously: state=IDLE, lives=0, time_left=0, tick=0, frame counter=0, game_over_screen=0, win=0, freeze=0, respawn=0.
REQ-032 Reset asserted mid-DYING or mid-FLAG SHALL abandon the sequence; after release, a new game starts only via REQ-020.

Configuration
REQ-033 Macro GAME_TIMER_EN defined: timer per REQ-021; time_left reaching 0 in PLAY is a timeout death on the following frame.
REQ-034 GAME_TIMER_EN undefined: tick logic absent, time_left held at START_TIME in all non-reset states, no timeout deaths.

Structure
REQ-035 Shared package game_pkg SHALL hold the flow_state_t enum and default constants START_LIVES, START_TIME, TICK_FRAMES, DEATH_FRAMES, FLAG_FRAMES.
REQ-036 SHALL instantiate one sub-module frame_timer (loadable down-counter with done pulse), used for DYING and FLAG durations.

Verification
REQ-037 Reset, game_active=1 -> PLAY next edge, lives=3, time_left=400; after 24 PLAY frames time_left=399.
REQ-038 mario_hit in PLAY -> DYING, lives=2, freeze=1 for 120 frames, respawn pulse 1 frame, time_left=400, back in PLAY.
REQ-039 Three deaths -> third DYING ends in GAMEOVER, game_over_screen=1; game_active=0 -> IDLE, output 0.
REQ-040 flag_reached and mario_hit same frame -> FLAG, lives unchanged; after 90 frames win=1.
REQ-041 GAME_TIMER_EN, START_TIME=2, TICK_FRAMES=4 -> time_left 0 after 8 frames, DYING on the next frame.
REQ-042 Reset_n pulsed low 50 frames into DYING -> IDLE immediately, freeze=0, lives=0.
